// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and default latencies for the E-stage multiply/divide unit.
// control_E imports the same select codes so both ends of start/busy agree.
package mult_div_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_arith_op(input logic [3:0] sel);
    return (sel >= MD_MULT) && (sel <= MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] sel);
    return (sel == MD_DIV) || (sel == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_md_latency_counter.sv
// Down-counter that models the fixed latency of a multiply/divide.
// done is high while the count sits at 1, i.e. on the final busy cycle.
module md_latency_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: computes on the start edge, holds busy for a
// fixed latency, then commits to HI/LO. Also services mthi/mtlo.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mult_div_sel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  // Handshake: start is sampled only on edges where busy is low; a start
  // seen while busy is dropped. busy rises the cycle after an accepted start
  // and falls on the commit edge, so new HI/LO appear with busy low.
  md_state_e   state, state_next;
  logic        load, commit, cnt_done;
  logic [CNT_W-1:0] load_val;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_sdiv, b_udiv, q_mag, r_mag;
  logic [31:0] res_hi, res_lo;
  logic        res_valid;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start && is_arith_op(mult_div_sel)) state_next = ST_RUN;
      ST_RUN:  if (cnt_done) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == ST_RUN);
    load     = (state == ST_IDLE) && start && is_arith_op(mult_div_sel);
    commit   = (state == ST_RUN) && cnt_done;
    load_val = is_div_op(mult_div_sel) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  end

  md_latency_counter #(.W(CNT_W)) u_latency (
    .clk      (clk),
    .rst      (reset),
    .load     (load),
    .load_val (load_val),
    .done     (cnt_done)
  );

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps instead of
  // overflowing; a zero divisor is replaced by 1 and the result discarded.
  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
    a_mag  = A[31] ? (~A + 32'd1) : A;
    b_mag  = B[31] ? (~B + 32'd1) : B;
    b_sdiv = (b_mag == 32'd0) ? 32'd1 : b_mag;
    b_udiv = (B == 32'd0) ? 32'd1 : B;
    q_mag  = a_mag / b_sdiv;
    r_mag  = a_mag % b_sdiv;

    res_hi    = 32'd0;
    res_lo    = 32'd0;
    res_valid = 1'b1;
    case (mult_div_sel)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        res_lo    = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
        res_hi    = A[31] ? (~r_mag + 32'd1) : r_mag;
        res_valid = (B != 32'd0);
      end
      MD_DIVU: begin
        res_lo    = A / b_udiv;
        res_hi    = A % b_udiv;
        res_valid = (B != 32'd0);
      end
      default: res_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_hi    <= 32'd0;
      pend_lo    <= 32'd0;
      pend_valid <= 1'b0;
      HI         <= 32'd0;
      LO         <= 32'd0;
    end else begin
      if (load) begin
        pend_hi    <= res_hi;
        pend_lo    <= res_lo;
        pend_valid <= res_valid;
      end
      if (commit) begin
        if (pend_valid) begin
          HI <= pend_hi;
          LO <= pend_lo;
        end
      end else if (state == ST_IDLE) begin
        if (mult_div_sel == MD_MTHI) HI <= A;
        if (mult_div_sel == MD_MTLO) LO <= A;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus multi-cycle sequences.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk, reset, start, busy;
  logic [3:0]  sel;
  logic [31:0] a_in, b_in, hi, lo;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mult_div_sel (sel),
    .A            (a_in),
    .B            (b_in),
    .busy         (busy),
    .HI           (hi),
    .LO           (lo)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // drivers
  task automatic do_op(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    @(negedge clk);
    start = 1'b1; sel = s; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0; sel = MD_NONE; a_in = '0; b_in = '0;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic move_to(input logic [3:0] s, input logic [31:0] a);
    @(negedge clk);
    sel = s; a_in = a;
    @(negedge clk);
    sel = MD_NONE; a_in = '0;
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; sel = MD_NONE; a_in = '0; b_in = '0;

    vecs[0] = '{MD_MULT,  32'hFFFFFFFF, 32'd2,        32'd5,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'd5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'd10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{MD_DIVU,  32'd7,        32'd2,        32'd10, 32'h00000001, 32'h00000003};
    vecs[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd10, 32'h00000000, 32'h80000000};
    vecs[5] = '{MD_MULT,  32'd7,        32'hFFFFFFFD, 32'd5,  32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[6] = '{MD_MULTU, 32'h00010000, 32'h00010000, 32'd5,  32'h00000001, 32'h00000000};
    vecs[7] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd10, 32'h00000001, 32'hFFFFFFFD};
    vecs[8] = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'd10, 32'h0000000F, 32'h0FFFFFFF};
    vecs[9] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'd5,  32'h40000000, 32'h00000000};

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].cycles);
      exp_q.push_back(vecs[i].hi);
      exp_q.push_back(vecs[i].lo);
      do_op(vecs[i].sel, vecs[i].a, vecs[i].b, n);
      check($sformatf("v%0d_cycles", i), 32'(n), exp_q.pop_front());
      check($sformatf("v%0d_hi", i), hi, exp_q.pop_front());
      check($sformatf("v%0d_lo", i), lo, exp_q.pop_front());
    end

    // divide by zero leaves preloaded HI/LO untouched
    move_to(MD_MTHI, 32'h11111111);
    move_to(MD_MTLO, 32'h22222222);
    check("mthi", hi, 32'h11111111);
    check("mtlo", lo, 32'h22222222);
    do_op(MD_DIV, 32'd5, 32'd0, n);
    check("div0_cycles", 32'(n), 32'd10);
    check("div0_hi", hi, 32'h11111111);
    check("div0_lo", lo, 32'h22222222);
    do_op(MD_DIVU, 32'd9, 32'd0, n);
    check("divu0_cycles", 32'(n), 32'd10);
    check("divu0_hi", hi, 32'h11111111);
    check("divu0_lo", lo, 32'h22222222);

    // wrap case with an mtlo held during busy
    @(negedge clk);
    start = 1'b1; sel = MD_DIV; a_in = 32'h80000000; b_in = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0; sel = MD_MTLO; a_in = 32'hDEADBEEF; b_in = '0;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      if (n == 4) begin sel = MD_NONE; a_in = '0; end
      @(negedge clk);
    end
    sel = MD_NONE; a_in = '0;
    check("wrap_cycles", 32'(n), 32'd10);
    check("wrap_hi", hi, 32'h00000000);
    check("wrap_lo", lo, 32'h80000000);

    // second start during busy is dropped
    @(negedge clk);
    start = 1'b1; sel = MD_MULT; a_in = 32'd3; b_in = 32'd4;
    @(negedge clk);
    start = 1'b0; sel = MD_NONE;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      if (n == 2) begin start = 1'b1; sel = MD_DIV; a_in = 32'd100; b_in = 32'd7; end
      else begin start = 1'b0; sel = MD_NONE; end
      @(negedge clk);
    end
    start = 1'b0; sel = MD_NONE;
    check("dup_cycles", 32'(n), 32'd5);
    check("dup_hi", hi, 32'd0);
    check("dup_lo", lo, 32'd12);

    // back-to-back with start held high: one idle cycle between operations
    @(negedge clk);
    start = 1'b1; sel = MD_MULT; a_in = 32'd6; b_in = 32'd7;
    @(negedge clk);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("b2b1_cycles", 32'(n), 32'd5);
    check("b2b1_hi", hi, 32'd0);
    check("b2b1_lo", lo, 32'd42);
    a_in = 32'd3; b_in = 32'd5;
    @(negedge clk);
    check("b2b_accept", {31'd0, busy}, 32'd1);
    start = 1'b0; sel = MD_NONE;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("b2b2_cycles", 32'(n), 32'd5);
    check("b2b2_hi", hi, 32'd0);
    check("b2b2_lo", lo, 32'd15);

    // reset in the second busy cycle discards the operation
    @(negedge clk);
    start = 1'b1; sel = MD_MULT; a_in = 32'd3; b_in = 32'd5;
    @(negedge clk);
    start = 1'b0; sel = MD_NONE;
    @(negedge clk);
    check("rmid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("rmid_busy", {31'd0, busy}, 32'd0);
    check("rmid_hi", hi, 32'd0);
    check("rmid_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("rmid_late_busy", {31'd0, busy}, 32'd0);
    check("rmid_late_hi", hi, 32'd0);
    check("rmid_late_lo", lo, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
